// File: rtl/ram_reader_pkg.sv
// Shared constants, FSM state type and default widths for the RAM read engine.
package ram_reader_pkg;

  localparam int unsigned BIT_DATA = 8;
  localparam int unsigned SZB_RAM  = 4;
  localparam int unsigned RD_DEPTH = 2;

  localparam logic ON  = 1'b1;
  localparam logic OFF = 1'b0;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_READ,
    RD_DRAIN,
    RD_FIN
  } rd_state_t;

endpackage

// File: rtl/ram_reader_skid_fifo.sv
// Two-entry synchronous FIFO that buffers words returned by the RAM.
module skid_fifo
  import ram_reader_pkg::*;
#(
  parameter int unsigned BIT = BIT_DATA
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           push,
  input  logic [BIT-1:0] push_data,
  input  logic           pop,
  output logic           empty,
  output logic           full,
  output logic [1:0]     occupancy,
  output logic [BIT-1:0] head
);

  logic [BIT-1:0] mem [RD_DEPTH];
  logic           wr_ptr;
  logic           rd_ptr;
  logic [1:0]     occ;
  logic           push_ok;
  logic           pop_ok;

  assign empty     = (occ == 2'd0);
  assign full      = (occ == 2'(RD_DEPTH));
  assign occupancy = occ;
  assign head      = mem[rd_ptr];
  assign push_ok   = push & ~full;
  assign pop_ok    = pop & ~empty;

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < RD_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      case ({push_ok, pop_ok})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/ram_reader.sv
// Sequential RAM read engine: issues credit-limited reads from base and
// streams the returned words over a valid/ready handshake.
module ram_reader
  import ram_reader_pkg::*;
#(
  parameter int unsigned BIT = BIT_DATA,
  parameter int unsigned SZB = SZB_RAM
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [SZB-1:0] base,
  input  logic [SZB:0]   count,
  output logic           busy,
  output logic           done,
  output logic [SZB-1:0] ram_addr,
  output logic           ram_we,
  input  logic [BIT-1:0] ram_q,
  output logic [BIT-1:0] out_data,
  output logic           out_valid,
  input  logic           out_ready
);

  rd_state_t  state;
  logic [SZB:0] remaining;
  logic       inflight;
  logic       issue;
  logic       pop;
  logic       fifo_empty;
  logic       fifo_full;
  logic [1:0] fifo_occ;
  logic [2:0] used;
  logic       drain_done;

  assign ram_we    = OFF;
  assign out_valid = ~fifo_empty;
  assign pop       = out_valid & out_ready;
  assign used      = {1'b0, fifo_occ} + {2'b00, inflight};

  // A pop on this edge frees a slot, so it counts as a returned credit.
  assign issue = (state == RD_READ) &&
                 ((used < 3'd2) || ((used == 3'd2) && pop));

  // Finished once nothing is in flight and the FIFO empties on this edge.
  assign drain_done = ~inflight && ~fifo_full && (fifo_empty || pop);

  skid_fifo #(.BIT(BIT)) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (inflight),
    .push_data (ram_q),
    .pop       (pop),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .occupancy (fifo_occ),
    .head      (out_data)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= RD_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      ram_addr  <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
    end else begin
      inflight <= issue;
      case (state)
        RD_IDLE: begin
          if (start) begin
            if (count == '0) begin
              state <= RD_FIN;
              done  <= 1'b1;
            end else begin
              state     <= RD_READ;
              busy      <= 1'b1;
              ram_addr  <= base;
              remaining <= count;
            end
          end
        end
        RD_READ: begin
          if (issue) begin
            ram_addr  <= ram_addr + 1'b1;
            remaining <= remaining - 1'b1;
            if (remaining == (SZB+1)'(1)) state <= RD_DRAIN;
          end
        end
        RD_DRAIN: begin
          if (drain_done) begin
            state <= RD_FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        RD_FIN: begin
          done  <= 1'b0;
          state <= RD_IDLE;
        end
        default: state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_reader.sv
// Self-checking bench for ram_reader with a registered-read RAM model and a
// queue-based expected word stream.
module tb_ram_reader;
  import ram_reader_pkg::*;

  localparam int unsigned BIT   = 8;
  localparam int unsigned SZB   = 4;
  localparam int unsigned DEPTH = 1 << SZB;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic [SZB-1:0] base;
  logic [SZB:0]   count;
  logic           busy;
  logic           done;
  logic [SZB-1:0] ram_addr;
  logic           ram_we;
  logic [BIT-1:0] ram_q;
  logic [BIT-1:0] out_data;
  logic           out_valid;
  logic           out_ready;

  logic [BIT-1:0] mem [DEPTH];

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  always #5 clock = ~clock;

  always @(posedge clock) ram_q <= mem[ram_addr];

  ram_reader #(.BIT(BIT), .SZB(SZB)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .base      (base),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_q     (ram_q),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; base = '0; count = '0; out_ready = 1'b0;
    repeat (3) @(negedge clock);
    n_cmp++;
    if ({busy, done, out_valid, out_data, ram_addr, ram_we} !== '0) begin
      n_err++;
      $display("FAIL reset_values: busy=%b done=%b valid=%b data=%h addr=%h we=%b, expected all zero",
               busy, done, out_valid, out_data, ram_addr, ram_we);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_basic();
    logic [BIT-1:0] exp_seq [4];
    mem[3] = 8'hA5; mem[4] = 8'h5A;
    out_ready = 1'b1; start = 1'b1; base = 4'd3; count = 5'd2;
    @(negedge clock);
    start = 1'b0;
    n_cmp++;
    if (ram_addr !== 4'd3 || busy !== 1'b1) begin
      n_err++; $display("FAIL basic_e0: addr=%h busy=%b, expected 3 and 1", ram_addr, busy);
    end
    @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL basic_e1_valid: got %b, expected 0", out_valid);
    end
    exp_seq[0] = 8'hA5; exp_seq[1] = 8'h5A;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== exp_seq[i] || done !== 1'b0) begin
        n_err++;
        $display("FAIL basic_word%0d: valid=%b data=%h done=%b, expected 1 %h 0",
                 i, out_valid, out_data, done, exp_seq[i]);
      end
    end
    @(negedge clock);
    n_cmp++;
    if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done: done=%b busy=%b valid=%b, expected 1 0 0", done, busy, out_valid);
    end
    @(negedge clock);
    n_cmp++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL basic_done_pulse: done=%b, expected 0", done);
    end
  endtask

  task automatic test_zero_count();
    logic [SZB-1:0] addr_before;
    addr_before = ram_addr;
    start = 1'b1; base = 4'd7; count = '0; out_ready = 1'b1;
    @(negedge clock);
    start = 1'b0;
    n_cmp++;
    if (done !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || ram_addr !== addr_before) begin
      n_err++;
      $display("FAIL zero_count: done=%b valid=%b busy=%b addr=%h, expected 1 0 0 %h",
               done, out_valid, busy, ram_addr, addr_before);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_cmp++;
      if (done !== 1'b0 || out_valid !== 1'b0 || ram_addr !== addr_before) begin
        n_err++;
        $display("FAIL zero_after%0d: done=%b valid=%b addr=%h, expected 0 0 %h",
                 i, done, out_valid, ram_addr, addr_before);
      end
    end
  endtask

  task automatic test_stream(input logic [SZB-1:0] b, input logic [SZB:0] c,
                             input int unsigned stall_pct, input bit mid_start);
    logic [BIT-1:0] exp_q [$];
    logic [BIT-1:0] want;
    logic [BIT-1:0] prev_data;
    bit prev_stall;
    bit finished;
    int unsigned budget;
    prev_stall = 1'b0;
    prev_data  = '0;
    finished   = 1'b0;
    budget     = 10 * int'(c) + 20;
    for (int i = 0; i < int'(c); i++) exp_q.push_back(mem[(int'(b) + i) % DEPTH]);
    start = 1'b1; base = b; count = c; out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    n_cmp++;
    if (ram_addr !== b || busy !== 1'b1) begin
      n_err++; $display("FAIL stream_first_addr: addr=%h busy=%b, expected %h 1", ram_addr, busy, b);
    end
    for (int unsigned cyc = 0; cyc < budget && !finished; cyc++) begin
      if (cyc > 0) @(negedge clock);
      start = 1'b0;
      if (mid_start && cyc == 2) begin
        start = 1'b1; base = b + 4'd5; count = 5'd1;
      end
      if (prev_stall) begin
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== prev_data) begin
          n_err++;
          $display("FAIL stall_hold: valid=%b data=%h, expected 1 %h", out_valid, out_data, prev_data);
        end
      end
      if (done === 1'b1) begin
        finished = 1'b1;
        n_cmp++;
        if (exp_q.size() != 0 || out_valid !== 1'b0 || busy !== 1'b0) begin
          n_err++;
          $display("FAIL stream_complete: left=%0d valid=%b busy=%b, expected 0 0 0",
                   exp_q.size(), out_valid, busy);
        end
      end else begin
        out_ready = ($urandom_range(99) >= stall_pct);
        if (out_valid === 1'b1 && out_ready) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_err++; $display("FAIL stream_extra: got %h, expected no further word", out_data);
          end else begin
            want = exp_q.pop_front();
            if (out_data !== want) begin
              n_err++; $display("FAIL stream_word: got %h, expected %h", out_data, want);
            end
          end
        end
        prev_stall = (out_valid === 1'b1) && !out_ready;
        prev_data  = out_data;
      end
    end
    if (!finished) begin
      n_cmp++; n_err++;
      $display("FAIL stream_timeout: done=%b, expected 1 within %0d cycles", done, budget);
    end
    start = 1'b0; out_ready = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset_mid_job();
    start = 1'b1; base = 4'd2; count = 5'd6; out_ready = 1'b0;
    @(negedge clock);
    start = 1'b0;
    repeat (2) @(negedge clock);
    n_cmp++;
    if (out_valid !== 1'b1) begin
      n_err++; $display("FAIL rst_mid_setup: valid=%b, expected 1", out_valid);
    end
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_data !== '0) begin
      n_err++;
      $display("FAIL rst_mid: valid=%b busy=%b done=%b data=%h, expected 0 0 0 00",
               out_valid, busy, done, out_data);
    end
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clock);
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0) begin
        n_err++; $display("FAIL rst_mid_idle: valid=%b busy=%b, expected 0 0", out_valid, busy);
      end
    end
    out_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) mem[i] = BIT'($urandom);
    test_reset();
    test_basic();
    @(negedge clock);
    test_zero_count();
    test_stream(4'hF, 5'd3, 0, 1'b0);
    test_stream(4'h0, 5'd16, 40, 1'b0);
    test_stream(4'h6, 5'd16, 0, 1'b0);
    test_stream(4'h9, 5'd8, 30, 1'b1);
    test_reset_mid_job();
    test_stream(4'h1, 5'd4, 20, 1'b0);
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] = BIT'($urandom);
      test_stream(SZB'($urandom), 5'($urandom_range(16, 1)), $urandom_range(60), 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
